// File: rtl/screenmem_arbiter.sv
// screenmem_arbiter: shares the single-port, synchronous-read screen RAM
// between the VGA tile fetch (absolute priority, one slot per tile) and a
// CPU req/ack port. The RAM returns data one clk after the address.
// Optional build macro: SCREENMEM_RANGE_CHECK_EN. When it is defined, CPU
// accesses to tile indices >= COLS*ROWS are acknowledged but never write,
// and reads of them return zero.
module screenmem_arbiter #(
    parameter int XBITS   = 10,
    parameter int YBITS   = 10,
    parameter int TW_LOG2 = 4,
    parameter int TH_LOG2 = 4,
    parameter int COLS    = 40,
    parameter int ROWS    = 30,
    parameter int AW      = 11,
    parameter int DW      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pix_tick,
    input  logic [XBITS-1:0] x,
    input  logic [YBITS-1:0] y,
    input  logic             activevideo,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [AW-1:0]    cpu_addr,
    input  logic [DW-1:0]    cpu_wdata,
    output logic             cpu_ack,
    output logic [DW-1:0]    cpu_rdata,
    output logic [AW-1:0]    mem_addr,
    output logic             mem_we,
    output logic [DW-1:0]    mem_wdata,
    input  logic [DW-1:0]    mem_rdata,
    output logic [DW-1:0]    char_code,
    output logic             char_valid
);

    typedef enum logic [1:0] {IDLE, CPU_ACC, CPU_DONE} state_t;

    state_t          state_reg, state_next;
    logic            tick_d_reg;
    logic            disp_pending_reg;
    logic            acc_read_reg;
    logic            acc_oor_reg;
    logic [AW-1:0]   addr_reg;
    logic [DW-1:0]   char_code_reg;
    logic [DW-1:0]   cpu_rdata_reg;

    logic            disp_slot;
    logic            grant;
    logic            cpu_in_range;
    logic [AW-1:0]   disp_index;

    // Tile index is computed modulo 2^AW, which equals truncating the full product.
    assign disp_index = AW'(y >> TH_LOG2) * AW'(COLS) + AW'(x >> TW_LOG2);

    // Display owns the port on the first clk of the first pixel of each visible tile.
    assign disp_slot = !reset && tick_d_reg && activevideo && (x[TW_LOG2-1:0] == '0);

`ifdef SCREENMEM_RANGE_CHECK_EN
    localparam logic [31:0] TILES = 32'(COLS * ROWS);
    assign cpu_in_range = (32'(cpu_addr) < TILES);
`else
    assign cpu_in_range = 1'b1;
`endif

    // Next-state logic; the CPU is granted in IDLE only when the display is not fetching.
    always_comb begin
        state_next = state_reg;
        grant      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (cpu_req && !disp_slot && !reset) begin
                    grant      = 1'b1;
                    state_next = CPU_ACC;
                end
            end
            CPU_ACC:  state_next = CPU_DONE;
            CPU_DONE: state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // RAM address mux: display first, then a CPU grant, otherwise hold the last address.
    always_comb begin
        mem_addr = addr_reg;
        if (disp_slot) begin
            mem_addr = disp_index;
        end else if (grant) begin
            mem_addr = cpu_addr;
        end
    end

    assign mem_we     = grant && cpu_we && cpu_in_range;
    assign mem_wdata  = cpu_wdata;

    // Results are presented in the clk the RAM data arrives and held in registers afterwards.
    assign cpu_ack    = !reset && (state_reg == CPU_ACC);
    assign cpu_rdata  = (cpu_ack && acc_read_reg) ? (acc_oor_reg ? '0 : mem_rdata)
                                                  : cpu_rdata_reg;
    assign char_valid = !reset && disp_pending_reg;
    assign char_code  = char_valid ? mem_rdata : char_code_reg;

    // State, pixel-tick delay, pending-fetch flags and held output values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= IDLE;
            tick_d_reg       <= 1'b0;
            disp_pending_reg <= 1'b0;
            acc_read_reg     <= 1'b0;
            acc_oor_reg      <= 1'b0;
            addr_reg         <= '0;
            char_code_reg    <= '0;
            cpu_rdata_reg    <= '0;
        end else begin
            state_reg        <= state_next;
            tick_d_reg       <= pix_tick;
            disp_pending_reg <= disp_slot;
            addr_reg         <= mem_addr;
            char_code_reg    <= char_code;
            cpu_rdata_reg    <= cpu_rdata;
            if (grant) begin
                acc_read_reg <= !cpu_we;
                acc_oor_reg  <= !cpu_in_range;
            end
        end
    end

endmodule

// File: tb/tb_screenmem_arbiter.sv
// Scoreboard bench for screenmem_arbiter: stimulus pushes expected events
// (RAM writes, CPU acks, character fetches, per-cycle probes) into queues;
// a negedge monitor pops and compares them against what the DUT presents.
module tb_screenmem_arbiter;

    localparam int AW = 11;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          pix_tick = 1'b0;
    logic [9:0]    x = '0;
    logic [9:0]    y = '0;
    logic          activevideo = 1'b0;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic [DW-1:0] char_code;
    logic          char_valid;

    screenmem_arbiter #(
        .XBITS(10), .YBITS(10), .TW_LOG2(4), .TH_LOG2(4),
        .COLS(40), .ROWS(30), .AW(AW), .DW(DW)
    ) dut (
        .clk(clk), .reset(reset), .pix_tick(pix_tick), .x(x), .y(y),
        .activevideo(activevideo), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
        .cpu_rdata(cpu_rdata), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .char_code(char_code),
        .char_valid(char_valid)
    );

    always #5 clk = ~clk;

    // Screen RAM model: synchronous read, one clk latency
    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
    typedef struct { int cyc; logic rd; logic [DW-1:0] data; } ack_t;
    typedef struct { int cyc; logic [DW-1:0] data; } chr_t;
    typedef struct { int cyc; int sig; logic [AW-1:0] val; } probe_t;

    wr_t    wr_q[$];
    ack_t   ack_q[$];
    chr_t   chr_q[$];
    probe_t probe_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic string sig_name(input int s);
        case (s)
            0: return "mem_addr";
            1: return "mem_we";
            2: return "cpu_ack";
            3: return "char_code";
            4: return "char_valid";
            default: return "cpu_rdata";
        endcase
    endfunction

    function automatic int sig_val(input int s);
        case (s)
            0: return int'(mem_addr);
            1: return int'(mem_we);
            2: return int'(cpu_ack);
            3: return int'(char_code);
            4: return int'(char_valid);
            default: return int'(cpu_rdata);
        endcase
    endfunction

    // Monitor: compares DUT events and probes against the scoreboard queues
    probe_t p;
    wr_t    w;
    ack_t   a;
    chr_t   ch;
    always @(negedge clk) begin
        while (probe_q.size() > 0 && probe_q[0].cyc <= cyc) begin
            p = probe_q.pop_front();
            chk($sformatf("probe_%s_c%0d", sig_name(p.sig), p.cyc), sig_val(p.sig), int'(p.val));
        end
        if (mem_we) begin
            if (wr_q.size() == 0) begin
                chk("unexpected_write_we", 1, 0);
            end else begin
                w = wr_q.pop_front();
                $display("write cyc=%0d addr=%0d data=%0h", cyc, mem_addr, mem_wdata);
                chk("write_cycle", cyc, w.cyc);
                chk("write_addr", int'(mem_addr), int'(w.addr));
                chk("write_data", int'(mem_wdata), int'(w.data));
            end
        end else if (wr_q.size() > 0 && wr_q[0].cyc < cyc) begin
            w = wr_q.pop_front();
            chk("missing_write_cycle", cyc, w.cyc);
        end
        if (cpu_ack) begin
            if (ack_q.size() == 0) begin
                chk("unexpected_ack", 1, 0);
            end else begin
                a = ack_q.pop_front();
                $display("ack   cyc=%0d rd=%0d rdata=%0h", cyc, a.rd, cpu_rdata);
                chk("ack_cycle", cyc, a.cyc);
                if (a.rd) chk("ack_rdata", int'(cpu_rdata), int'(a.data));
            end
        end else if (ack_q.size() > 0 && ack_q[0].cyc < cyc) begin
            a = ack_q.pop_front();
            chk("missing_ack_cycle", cyc, a.cyc);
        end
        if (char_valid) begin
            if (chr_q.size() == 0) begin
                chk("unexpected_char_valid", 1, 0);
            end else begin
                ch = chr_q.pop_front();
                $display("char  cyc=%0d code=%0h", cyc, char_code);
                chk("char_cycle", cyc, ch.cyc);
                chk("char_code", int'(char_code), int'(ch.data));
            end
        end else if (chr_q.size() > 0 && chr_q[0].cyc < cyc) begin
            ch = chr_q.pop_front();
            chk("missing_char_cycle", cyc, ch.cyc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input int c, input int s, input int v);
        probe_q.push_back('{cyc: c, sig: s, val: AW'(v)});
    endtask

    // Single CPU access; requester drops req in the clk after ack
    task automatic cpu_single(input logic we, input int addr, input int wd,
                              input int exp_rd, input logic wr_expected);
        int c;
        step();
        c = cyc;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = AW'(addr); cpu_wdata = DW'(wd);
        if (we && wr_expected) wr_q.push_back('{cyc: c, addr: AW'(addr), data: DW'(wd)});
        if (we && !wr_expected) probe(c, 1, 0);
        ack_q.push_back('{cyc: c + 1, rd: !we, data: DW'(exp_rd)});
        step();
        step();
        cpu_req = 1'b0;
        step();
    endtask

    initial begin
        int c;
        for (int i = 0; i < (1 << AW); i++) ram[i] = '0;
        ram[122]  = 4'hA;
        ram[10]   = 4'h3;
        ram[0]    = 4'h6;
        ram[2047] = 4'h5;

        // Reset state
        repeat (3) step();
        reset = 1'b0;
        c = cyc;
        probe(c, 0, 0); probe(c, 1, 0); probe(c, 2, 0);
        probe(c, 3, 0); probe(c, 4, 0); probe(c, 5, 0);

        // Display fetch of tile (2,3) -> index 122
        step();
        pix_tick = 1'b1; x = 10'd32; y = 10'd48; activevideo = 1'b1;
        step();
        pix_tick = 1'b0;
        c = cyc;
        probe(c, 0, 122); probe(c, 1, 0);
        chr_q.push_back('{cyc: c + 1, data: 4'hA});
        step();
        // Blanking: tick without activevideo -> no fetch, address and char held
        step();
        pix_tick = 1'b1; activevideo = 1'b0; x = 10'd0;
        step();
        pix_tick = 1'b0;
        c = cyc;
        probe(c, 0, 122); probe(c + 1, 4, 0); probe(c + 1, 3, 'hA);
        // Unaligned x -> no fetch
        step();
        pix_tick = 1'b1; x = 10'd33; activevideo = 1'b1;
        step();
        pix_tick = 1'b0;
        c = cyc;
        probe(c + 1, 4, 0); probe(c + 1, 3, 'hA);
        step();
        activevideo = 1'b0;
        step();

        // CPU write addr 5 data 7, then address hold and read-back
        cpu_single(1'b1, 5, 7, 0, 1'b1);
        probe(cyc - 2, 0, 5);
        cpu_single(1'b0, 5, 0, 7, 1'b1);
        probe(cyc, 5, 7);
        step();

        // Collision: req rises in the display slot for tile (0,0)
        pix_tick = 1'b1; x = 10'd0; y = 10'd0; activevideo = 1'b1;
        step();
        pix_tick = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'd10;
        c = cyc;
        probe(c, 0, 0); probe(c + 1, 0, 10); probe(c, 1, 0);
        chr_q.push_back('{cyc: c + 1, data: 4'h6});
        ack_q.push_back('{cyc: c + 2, rd: 1'b1, data: 4'h3});
        step();
        step();
        step();
        cpu_req = 1'b0; activevideo = 1'b0;
        step();

        // Held req across back-to-back writes (20<-9, 21<-4)
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'd20; cpu_wdata = 4'h9;
        c = cyc;
        wr_q.push_back('{cyc: c, addr: 11'd20, data: 4'h9});
        ack_q.push_back('{cyc: c + 1, rd: 1'b0, data: 4'h0});
        wr_q.push_back('{cyc: c + 3, addr: 11'd21, data: 4'h4});
        ack_q.push_back('{cyc: c + 4, rd: 1'b0, data: 4'h0});
        probe(c + 1, 1, 0); probe(c + 2, 1, 0); probe(c + 2, 2, 0);
        step();
        cpu_addr = 11'd21; cpu_wdata = 4'h4;
        step(); step(); step(); step();
        cpu_req = 1'b0;
        step();

        // Held req across back-to-back reads of 20 then 21
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'd20;
        c = cyc;
        ack_q.push_back('{cyc: c + 1, rd: 1'b1, data: 4'h9});
        ack_q.push_back('{cyc: c + 4, rd: 1'b1, data: 4'h4});
        probe(c + 3, 0, 21);
        step();
        cpu_addr = 11'd21;
        step(); step(); step(); step();
        cpu_req = 1'b0;
        step();

`ifdef SCREENMEM_RANGE_CHECK_EN
        // Out-of-range accesses: acked, no write, read returns zero
        cpu_single(1'b1, 1200, 15, 0, 1'b0);
        cpu_single(1'b0, 2047, 0, 0, 1'b1);
`endif

        // Reset during CPU_ACC of a read aborts it without an ack
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'd5;
        c = cyc;
        step();
        reset = 1'b1;
        probe(c + 1, 2, 0);
        step();
        reset = 1'b0; cpu_req = 1'b0;
        probe(c + 2, 2, 0); probe(c + 2, 1, 0); probe(c + 2, 3, 0);
        probe(c + 2, 0, 0); probe(c + 2, 5, 0);
        repeat (4) step();

        // Anything still queued was never observed
        while (probe_q.size() > 0) begin void'(probe_q.pop_front()); chk("probe_not_reached", 1, 0); end
        while (wr_q.size() > 0)    begin void'(wr_q.pop_front());    chk("write_not_seen", 1, 0); end
        while (ack_q.size() > 0)   begin void'(ack_q.pop_front());   chk("ack_not_seen", 1, 0); end
        while (chr_q.size() > 0)   begin void'(chr_q.pop_front());   chk("char_not_seen", 1, 0); end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
